// File: rtl/ixu_pkg.sv
// Shared integer-execution types: register index and word typedefs used by the
// writeback stage and the architectural register file.
package ixu_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       word_t;
endpackage

// File: rtl/ixu_regfile_wr_sel.sv
// Writeback selector: for one register index, reports whether any effective
// slot writes it and which slot wins (highest index has priority).
module ixu_regfile_wr_sel
  import ixu_pkg::*;
#(
  parameter int NUM_WR = 2,
  parameter int SEL_W  = (NUM_WR > 1) ? $clog2(NUM_WR) : 1
) (
  input  reg_addr_t         idx,
  input  logic [NUM_WR-1:0] wr_en,
  input  reg_addr_t         wr_rd [NUM_WR],
  output logic              hit,
  output logic [SEL_W-1:0]  sel
);

  // Ascending scan so the last match, the highest slot, overrides earlier ones.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      if (wr_en[i] && (wr_rd[i] != '0) && (wr_rd[i] == idx)) begin
        hit = 1'b1;
        sel = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/ixu_regfile.sv
// Integer architectural register file: multi-slot writeback commit, bypassed
// combinational read ports, hardwired x0 and collision reporting.
module ixu_regfile
  import ixu_pkg::*;
#(
  parameter int NUM_WR = 2,
  parameter int NUM_RD = 4,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_WR-1:0] wr_en,
  input  reg_addr_t         wr_rd   [NUM_WR],
  input  logic [XLEN-1:0]   wr_data [NUM_WR],
  input  reg_addr_t         rd_addr [NUM_RD],
  output logic [XLEN-1:0]   rd_data [NUM_RD],
  output logic              wr_conflict,
  output logic [7:0]        conflict_cnt
);

  localparam int SEL_W = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [XLEN-1:0]  regs       [1:NUM_REGS-1];
  logic             commit_hit [1:NUM_REGS-1];
  logic [SEL_W-1:0] commit_sel [1:NUM_REGS-1];
  logic             byp_hit    [NUM_RD];
  logic [SEL_W-1:0] byp_sel    [NUM_RD];
  logic             conflict_now;

  // Commit decode: one selector per stored register
  for (genvar r = 1; r < NUM_REGS; r++) begin : g_commit
    ixu_regfile_wr_sel #(.NUM_WR(NUM_WR), .SEL_W(SEL_W)) u_sel (
      .idx   (REG_ADDR_W'(r)),
      .wr_en (wr_en),
      .wr_rd (wr_rd),
      .hit   (commit_hit[r]),
      .sel   (commit_sel[r])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 1; r < NUM_REGS; r++) regs[r] <= '0;
    end else begin
      for (int r = 1; r < NUM_REGS; r++)
        if (commit_hit[r]) regs[r] <= wr_data[commit_sel[r]];
    end
  end

  // Read ports: same priority rule as commit, so bypass matches what will land
  for (genvar p = 0; p < NUM_RD; p++) begin : g_read
    ixu_regfile_wr_sel #(.NUM_WR(NUM_WR), .SEL_W(SEL_W)) u_sel (
      .idx   (rd_addr[p]),
      .wr_en (wr_en),
      .wr_rd (wr_rd),
      .hit   (byp_hit[p]),
      .sel   (byp_sel[p])
    );

    always_comb begin
      rd_data[p] = '0;
      if (rst_n && (rd_addr[p] != '0)) begin
        if (byp_hit[p]) rd_data[p] = wr_data[byp_sel[p]];
        else            rd_data[p] = regs[rd_addr[p]];
      end
    end
  end

  always_comb begin
    conflict_now = 1'b0;
    for (int i = 0; i < NUM_WR; i++)
      for (int j = i + 1; j < NUM_WR; j++)
        if (wr_en[i] && wr_en[j] && (wr_rd[i] != '0) && (wr_rd[i] == wr_rd[j]))
          conflict_now = 1'b1;
  end

  // Collision reporting stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_conflict  <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      wr_conflict <= conflict_now;
      if (conflict_now) conflict_cnt <= sat_inc(conflict_cnt);
    end
  end

endmodule

// File: tb/tb_ixu_regfile.sv
// Bench for ixu_regfile: behavioural model compared every cycle, plus directed
// literal checks for reset, bypass, x0, collisions, saturation and reset mid-run.
module tb_ixu_regfile;
  localparam int NUM_WR = 2;
  localparam int NUM_RD = 4;
  localparam int XLEN   = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NUM_WR-1:0] wr_en;
  logic [4:0]        wr_rd   [NUM_WR];
  logic [XLEN-1:0]   wr_data [NUM_WR];
  logic [4:0]        rd_addr [NUM_RD];
  logic [XLEN-1:0]   rd_data [NUM_RD];
  logic              wr_conflict;
  logic [7:0]        conflict_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  ixu_regfile #(.NUM_WR(NUM_WR), .NUM_RD(NUM_RD), .XLEN(XLEN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_rd        (wr_rd),
    .wr_data      (wr_data),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .wr_conflict  (wr_conflict),
    .conflict_cnt (conflict_cnt)
  );

  function void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: architectural state as a plain array and counters
  logic [XLEN-1:0] mregs [32];
  bit              mconf;
  int              mcnt;

  function bit is_eff(int i);
    return wr_en[i] && (wr_rd[i] != 5'd0);
  endfunction

  function bit model_conflict();
    for (int i = 0; i < NUM_WR; i++)
      for (int j = i + 1; j < NUM_WR; j++)
        if (is_eff(i) && is_eff(j) && wr_rd[i] == wr_rd[j]) return 1'b1;
    return 1'b0;
  endfunction

  function logic [XLEN-1:0] model_read(logic [4:0] a);
    logic [XLEN-1:0] v;
    if (!rst_n || a == 5'd0) return '0;
    v = mregs[a];
    for (int i = 0; i < NUM_WR; i++)
      if (is_eff(i) && wr_rd[i] == a) v = wr_data[i];
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) mregs[r] = '0;
      mconf = 1'b0;
      mcnt  = 0;
    end else begin
      bit c;
      c = model_conflict();
      for (int i = 0; i < NUM_WR; i++)
        if (is_eff(i)) mregs[wr_rd[i]] = wr_data[i];
      mconf = c;
      if (c && mcnt < 255) mcnt++;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      for (int p = 0; p < NUM_RD; p++)
        chk($sformatf("model_rd%0d_x%0d", p, rd_addr[p]), rd_data[p], model_read(rd_addr[p]));
      chk("model_wr_conflict", {31'd0, wr_conflict}, {31'd0, mconf});
      chk("model_conflict_cnt", {24'd0, conflict_cnt}, 32'(mcnt));
    end
  end

  task automatic idle();
    wr_en = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      wr_rd[i]   = 5'd0;
      wr_data[i] = '0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    for (int p = 0; p < NUM_RD; p++) rd_addr[p] = 5'd0;
    tick();
    tick();
    checking = 1'b1;

    // Reset held: every register on every port reads zero
    for (int r = 1; r < 32; r++) begin
      for (int p = 0; p < NUM_RD; p++) rd_addr[p] = 5'(r);
      #2;
      if (r == 1 || r == 31) begin
        chk("reset_rd0", rd_data[0], 32'h0);
        chk("reset_rd3", rd_data[3], 32'h0);
      end
      tick();
    end
    chk("reset_wr_conflict", {31'd0, wr_conflict}, 32'd0);
    chk("reset_conflict_cnt", {24'd0, conflict_cnt}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Write and readback through bypass then array
    wr_en[0] = 1'b1; wr_rd[0] = 5'd5; wr_data[0] = 32'hDEADBEEF; rd_addr[0] = 5'd5;
    #2 chk("x5_bypass", rd_data[0], 32'hDEADBEEF);
    tick();
    idle();
    #2 chk("x5_array", rd_data[0], 32'hDEADBEEF);
    tick();

    // x0 write is discarded
    wr_en[1] = 1'b1; wr_rd[1] = 5'd0; wr_data[1] = 32'h12345678; rd_addr[1] = 5'd0;
    #2 chk("x0_same_cycle", rd_data[1], 32'h0);
    tick();
    idle();
    #2 chk("x0_next_cycle", rd_data[1], 32'h0);
    chk("x0_no_conflict", {31'd0, wr_conflict}, 32'd0);
    tick();

    // Same-register collision: slot1 wins
    wr_en = 2'b11;
    wr_rd[0] = 5'd7; wr_data[0] = 32'h11111111;
    wr_rd[1] = 5'd7; wr_data[1] = 32'h22222222;
    rd_addr[2] = 5'd7;
    #2 chk("x7_collide_bypass", rd_data[2], 32'h22222222);
    tick();
    idle();
    #2 chk("x7_collide_array", rd_data[2], 32'h22222222);
    chk("collide_pulse", {31'd0, wr_conflict}, 32'd1);
    chk("collide_cnt", {24'd0, conflict_cnt}, 32'd1);
    tick();
    chk("collide_pulse_end", {31'd0, wr_conflict}, 32'd0);
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NUM_WR; i++) begin
        wr_en[i]   = ($urandom_range(0, 3) != 0);
        wr_rd[i]   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                 : 5'($urandom_range(0, 4));
        wr_data[i] = $urandom;
      end
      for (int p = 0; p < NUM_RD; p++)
        rd_addr[p] = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 31))
                                                 : 5'($urandom_range(0, 4));
      tick();
    end

    // 300 consecutive collisions on x3
    for (int n = 0; n < 300; n++) begin
      wr_en = 2'b11;
      wr_rd[0] = 5'd3; wr_data[0] = $urandom;
      wr_rd[1] = 5'd3; wr_data[1] = $urandom;
      rd_addr[0] = 5'd3;
      #2;
      if (n > 0 && (n % 50 == 0)) chk("sat_conflict_held", {31'd0, wr_conflict}, 32'd1);
      tick();
    end
    idle();
    #2 chk("sat_cnt_255", {24'd0, conflict_cnt}, 32'd255);
    chk("sat_conflict_lag", {31'd0, wr_conflict}, 32'd1);
    tick();
    chk("sat_cnt_hold", {24'd0, conflict_cnt}, 32'd255);
    chk("sat_conflict_drop", {31'd0, wr_conflict}, 32'd0);

    // Reset between edges while a write to x10 is pending
    wr_en[0] = 1'b1; wr_rd[0] = 5'd9; wr_data[0] = 32'hCAFEF00D;
    tick();
    idle();
    wr_en[0] = 1'b1; wr_rd[0] = 5'd10; wr_data[0] = 32'h00000055;
    rd_addr[0] = 5'd9; rd_addr[1] = 5'd10;
    #2 chk("x9_before_reset", rd_data[0], 32'hCAFEF00D);
    chk("x10_bypass_before_reset", rd_data[1], 32'h00000055);
    rst_n = 1'b0;
    #1 chk("x9_in_reset", rd_data[0], 32'h0);
    chk("x10_in_reset", rd_data[1], 32'h0);
    chk("cnt_in_reset", {24'd0, conflict_cnt}, 32'd0);
    tick();
    wr_en = '0;
    #1 rst_n = 1'b1;
    #1 chk("x9_after_release", rd_data[0], 32'h0);
    chk("x10_after_release", rd_data[1], 32'h0);
    tick();
    chk("x10_never_committed", rd_data[1], 32'h0);
    tick();

    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
